stdout_line_arbiter: RTL

Collects per-core stdout characters from the APB stdout write path into per-source line buffers. Each source is one (cluster, core) pair. Whole lines are drained one at a time onto a single byte stream, which feeds a host FIFO or UART. A round-robin arbiter shares the stream between sources so that lines from different cores never interleave. The block sits between the APB stdout decode and the debug/host output channel.

---
 rtl/stdout_line_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/stdout_line_arbiter.sv
// stdout_line_arbiter: gathers per-core stdout characters into per-source line
// buffers and drains whole lines, one at a time, onto a single byte stream.
// Sources are shared round-robin so that lines from different cores never interleave.
// Optional macro STDOUT_ARB_TIMEOUT_EN: when defined, a partial line that has been
// idle for TIMEOUT_CYCLES cycles is flushed as if flush_i had been pulsed.
module stdout_line_arbiter #(
  parameter int N_CLUSTERS     = 4,
  parameter int N_CORES        = 8,
  parameter int LINE_LEN       = 64,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int N_SRC         = N_CLUSTERS * N_CORES,
  localparam int SRC_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_valid_i,
  input  logic [3:0]       wr_cl_i,
  input  logic [3:0]       wr_core_i,
  input  logic [7:0]       wr_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic [SRC_W-1:0] out_src_o,
  output logic             out_last_o,
  output logic [15:0]      drop_cnt_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(LINE_LEN + 1);
  localparam int IDX_W = $clog2(LINE_LEN);

  // Reject configurations the index arithmetic below cannot represent.
  if (N_CLUSTERS < 1 || N_CLUSTERS > 16 || N_CORES < 1 || N_CORES > 16 ||
      LINE_LEN < 2 || (LINE_LEN & (LINE_LEN - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : gBadParam
    $error("stdout_line_arbiter: unsupported parameter combination");
  end

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } arbState_e;

  arbState_e        state_q;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] rrPtr_q;
  logic [IDX_W-1:0] rdIdx_q;
  logic             outValid_q;
  logic [15:0]      dropCnt_q;

  logic [N_SRC-1:0] lineReady_q, lineReady_d;
  logic [CNT_W-1:0] lineCnt_q [N_SRC];
  logic [CNT_W-1:0] lineCnt_d [N_SRC];
  logic [7:0]       lineBuf_q [N_SRC][LINE_LEN];

  logic             wrHit, wrAccept, wrStore, wrDrop;
  logic [8:0]       wrFlat;
  logic [SRC_W-1:0] wrSrc;
  logic             lastBeat, drainDone;
  logic             pickFound;
  logic [SRC_W-1:0] pickSrc;
  logic [N_SRC-1:0] timeoutHit;

  // Writes outside the configured cluster/core range never reach a buffer.
  assign wrHit    = wr_valid_i && ({1'b0, wr_cl_i} < 5'(N_CLUSTERS)) &&
                    ({1'b0, wr_core_i} < 5'(N_CORES));
  assign wrFlat   = 9'(wr_cl_i) * 9'(N_CORES) + 9'(wr_core_i);
  assign wrSrc    = wrFlat[SRC_W-1:0];
  assign wrAccept = wrHit && !lineReady_q[wrSrc];
  assign wrStore  = wrAccept && (wr_data_i != 8'h0A);
  assign wrDrop   = wrHit && lineReady_q[wrSrc];

  assign lastBeat  = (CNT_W'(rdIdx_q) == lineCnt_q[grant_q] - CNT_W'(1));
  assign drainDone = (state_q == ST_STREAM) && out_ready_i && lastBeat;

`ifdef STDOUT_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idleCnt_q [N_SRC];

  // Per-source idle counters: restart on every accepted write, run only while a partial line waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_SRC; i++) idleCnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (wrAccept && wrSrc == SRC_W'(i)) idleCnt_q[i] <= '0;
        else if (lineReady_q[SRC_W'(i)] || lineCnt_q[i] == '0) idleCnt_q[i] <= '0;
        else if (idleCnt_q[i] != TO_W'(TIMEOUT_CYCLES)) idleCnt_q[i] <= idleCnt_q[i] + TO_W'(1);
      end
    end
  end

  // A partial line whose counter has reached the limit is flushed like flush_i.
  always_comb begin
    timeoutHit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      timeoutHit[SRC_W'(i)] = !lineReady_q[SRC_W'(i)] && (lineCnt_q[i] != '0) &&
                              (idleCnt_q[i] == TO_W'(TIMEOUT_CYCLES));
    end
  end
`else
  assign timeoutHit = '0;
`endif

  // Per-source line state: the write is applied first, then flush/timeout, then drain completion.
  always_comb begin
    lineReady_d = lineReady_q;
    for (int i = 0; i < N_SRC; i++) lineCnt_d[i] = lineCnt_q[i];
    if (wrAccept) begin
      if (wr_data_i == 8'h0A) begin
        if (lineCnt_q[wrSrc] != '0) lineReady_d[wrSrc] = 1'b1;
      end else begin
        lineCnt_d[wrSrc] = lineCnt_q[wrSrc] + CNT_W'(1);
        if (lineCnt_q[wrSrc] == CNT_W'(LINE_LEN - 1)) lineReady_d[wrSrc] = 1'b1;
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if ((flush_i || timeoutHit[SRC_W'(i)]) && lineCnt_d[i] != '0) lineReady_d[SRC_W'(i)] = 1'b1;
    end
    if (drainDone) begin
      lineReady_d[grant_q] = 1'b0;
      lineCnt_d[grant_q]   = '0;
    end
  end

  // Line state registers and the saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lineReady_q <= '0;
      for (int i = 0; i < N_SRC; i++) lineCnt_q[i] <= '0;
      dropCnt_q <= '0;
    end else begin
      lineReady_q <= lineReady_d;
      for (int i = 0; i < N_SRC; i++) lineCnt_q[i] <= lineCnt_d[i];
      if (wrDrop && dropCnt_q != 16'hFFFF) dropCnt_q <= dropCnt_q + 16'd1;
    end
  end

  // Character storage; contents are only meaningful below each source's count.
  always_ff @(posedge clk_i) begin
    if (wrStore) lineBuf_q[wrSrc][lineCnt_q[wrSrc][IDX_W-1:0]] <= wr_data_i;
  end

  // Round-robin pick: first READY source at or after the pointer, wrapping.
  always_comb begin
    logic [SRC_W-1:0] jIdx;
    jIdx      = '0;
    pickFound = 1'b0;
    pickSrc   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      jIdx = SRC_W'((int'(rrPtr_q) + i) % N_SRC);
      if (!pickFound && lineReady_q[jIdx]) begin
        pickFound = 1'b1;
        pickSrc   = jIdx;
      end
    end
  end

  // Arbiter FSM: grant a line, stream it to the last byte, advance the pointer past it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rrPtr_q    <= '0;
      rdIdx_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pickFound) begin
            grant_q    <= pickSrc;
            rdIdx_q    <= '0;
            outValid_q <= 1'b1;
            state_q    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (out_ready_i) begin
            if (lastBeat) begin
              outValid_q <= 1'b0;
              state_q    <= ST_IDLE;
              rrPtr_q    <= (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
            end else begin
              rdIdx_q <= rdIdx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid_o = outValid_q;
  assign out_data_o  = outValid_q ? lineBuf_q[grant_q][rdIdx_q] : 8'h00;
  assign out_src_o   = outValid_q ? grant_q : '0;
  assign out_last_o  = outValid_q && lastBeat;
  assign drop_cnt_o  = dropCnt_q;
  assign busy_o      = (state_q != ST_IDLE) || (|lineReady_q);

endmodule
